// File: rtl/dispatch_unit_pkg.sv
// Shared dispatch definitions: ROB tag width, FUType codes, micro-op packing
// layout and reservation-station bit order.
// Optional feature macro used by this block: DISPATCH_CDB_SNOOP_EN.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

package dispatch_unit_pkg;

    localparam int unsigned ROB_W_DEF = `ROB_ENTRY_WIDTH;

    // FUType encodings
    localparam logic [2:0] FU_ALU = 3'd1;
    localparam logic [2:0] FU_MEM = 3'd2;
    localparam logic [2:0] FU_BRA = 3'd3;
    localparam logic [2:0] FU_MUL = 3'd4;

    // RS_ready / disp_valid bit order
    localparam int unsigned RS_ALU = 0;
    localparam int unsigned RS_MEM = 1;
    localparam int unsigned RS_BRA = 2;
    localparam int unsigned RS_MUL = 3;

    // Field widths of the packed micro-op
    localparam int unsigned IMM_W     = 32;
    localparam int unsigned BRACTRL_W = 3;
    localparam int unsigned MEMCTRL_W = 3;
    localparam int unsigned ALUCTRL_W = 4;
    localparam int unsigned OPSEL_W   = 2;
    localparam int unsigned FUTYPE_W  = 3;
    localparam int unsigned OPCODE_W  = 7;

    // Field LSBs; packing is {PC, inst, OpCode, FUType, OpASel, OpBSel,
    // ROB_dest, ALUCtrl, MemCtrl, BRACtrl, Imm} with Imm at bit 0.
    localparam int unsigned IMM_LSB      = 0;
    localparam int unsigned BRACTRL_LSB  = IMM_LSB + IMM_W;
    localparam int unsigned MEMCTRL_LSB  = BRACTRL_LSB + BRACTRL_W;
    localparam int unsigned ALUCTRL_LSB  = MEMCTRL_LSB + MEMCTRL_W;
    localparam int unsigned ROBDEST_LSB  = ALUCTRL_LSB + ALUCTRL_W;
    localparam int unsigned OPBSEL_LSB   = ROBDEST_LSB + ROB_W_DEF;
    localparam int unsigned OPASEL_LSB   = OPBSEL_LSB + OPSEL_W;
    localparam int unsigned FUTYPE_LSB   = OPASEL_LSB + OPSEL_W;
    localparam int unsigned OPCODE_LSB   = FUTYPE_LSB + FUTYPE_W;
    localparam int unsigned INST_LSB     = OPCODE_LSB + OPCODE_W;
    localparam int unsigned PC_LSB       = INST_LSB + 32;
    localparam int unsigned DISP_UOP_W   = PC_LSB + 32;

    // One-hot RS strobe for a FUType; all-zero means illegal
    function automatic logic [3:0] fu_decode(input logic [2:0] fu);
        logic [3:0] oh;
        oh = 4'b0000;
        unique case (fu)
            FU_ALU:  oh[RS_ALU] = 1'b1;
            FU_MEM:  oh[RS_MEM] = 1'b1;
            FU_BRA:  oh[RS_BRA] = 1'b1;
            FU_MUL:  oh[RS_MUL] = 1'b1;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/dispatch_unit_operand_capture.sv
// Held source operand (value, producer tag, ready) with optional CDB snoop.
// Optional feature macro: DISPATCH_CDB_SNOOP_EN.
module operand_capture #(
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             hold,
    input  logic [31:0]      value_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             rdy_in,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    output logic [31:0]      value,
    output logic [TAG_W-1:0] tag,
    output logic             rdy
);

    logic [31:0]      value_q, value_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             rdy_q, rdy_d;

    // Next operand: load new one, or wake the held one from the CDB
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        rdy_d   = rdy_q;
        if (load) begin
            value_d = value_in;
            tag_d   = tag_in;
            rdy_d   = rdy_in;
`ifdef DISPATCH_CDB_SNOOP_EN
            if (!rdy_in && cdb_valid && (cdb_tag == tag_in)) begin
                value_d = cdb_value;
                rdy_d   = 1'b1;
            end
`endif
        end else if (hold) begin
`ifdef DISPATCH_CDB_SNOOP_EN
            if (!rdy_q && cdb_valid && (cdb_tag == tag_q)) begin
                value_d = cdb_value;
                rdy_d   = 1'b1;
            end
`endif
        end
    end

`ifndef DISPATCH_CDB_SNOOP_EN
    logic unused_cdb;
    assign unused_cdb = ^{cdb_valid, cdb_tag, cdb_value};
`endif

    // Operand register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            tag_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
            rdy_q   <= rdy_d;
        end
    end

    assign value = value_q;
    assign tag   = tag_q;
    assign rdy   = rdy_q;

endmodule

// File: rtl/dispatch_unit.sv
// One-entry dispatch stage: holds a renamed micro-op and strobes it into the
// reservation station selected by FUType, stalling upstream when that RS is full.
// Optional feature macro: DISPATCH_CDB_SNOOP_EN (operand wakeup from the CDB).
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

module dispatch_unit
    import dispatch_unit_pkg::*;
#(
    parameter int unsigned ROB_W = `ROB_ENTRY_WIDTH,
    parameter int unsigned UOP_W = DISP_UOP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [UOP_W-1:0] uop_DP,
    input  logic [31:0]      OpAValue_DP,
    input  logic [ROB_W-1:0] OpA_RNB_index_DP,
    input  logic             OpA_rdy_DP,
    input  logic [31:0]      OpBValue_DP,
    input  logic [ROB_W-1:0] OpB_RNB_index_DP,
    input  logic             OpB_rdy_DP,
    input  logic             CDB_valid,
    input  logic [ROB_W-1:0] CDB_ROB_tag,
    input  logic [31:0]      CDB_value,
    input  logic [3:0]       RS_ready,
    output logic             stall_DP,
    output logic [UOP_W-1:0] uop_DS,
    output logic [31:0]      OpAValue_DS,
    output logic [ROB_W-1:0] OpA_RNB_index_DS,
    output logic             OpA_rdy_DS,
    output logic [31:0]      OpBValue_DS,
    output logic [ROB_W-1:0] OpB_RNB_index_DS,
    output logic             OpB_rdy_DS,
    output logic [3:0]       disp_valid_DS,
    output logic             illegal_fu_DS
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic [UOP_W-1:0] uop_q;
    logic             in_valid, full, legal, fire, capture;
    logic [3:0]       target;

    assign in_valid = |uop_DP[INST_LSB +: 32];
    assign full     = (state_q == StFull);
    assign target   = fu_decode(uop_q[FUTYPE_LSB +: FUTYPE_W]);
    assign legal    = |target;

    // Fire/capture decisions, next state and dispatch strobes
    always_comb begin
        fire          = 1'b0;
        capture       = 1'b0;
        state_d       = state_q;
        disp_valid_DS = 4'b0000;
        illegal_fu_DS = 1'b0;
        stall_DP      = 1'b0;
        if (!rst) begin
            if (full) begin
                disp_valid_DS = target;
                illegal_fu_DS = !legal;
                // An illegal entry is dropped as though it had dispatched
                fire          = legal ? |(target & RS_ready) : 1'b1;
            end
            capture  = in_valid && (!full || fire) && !flush;
            stall_DP = full && !fire && !flush;
            if (flush) begin
                state_d = StEmpty;
            end else if (capture) begin
                state_d = StFull;
            end else if (fire) begin
                state_d = StEmpty;
            end
        end else begin
            state_d = StEmpty;
        end
    end

    // State and held micro-op
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            uop_q   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                uop_q <= uop_DP;
            end
        end
    end

    assign uop_DS = uop_q;

    operand_capture #(
        .TAG_W (ROB_W)
    ) u_opa (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .hold      (full),
        .value_in  (OpAValue_DP),
        .tag_in    (OpA_RNB_index_DP),
        .rdy_in    (OpA_rdy_DP),
        .cdb_valid (CDB_valid),
        .cdb_tag   (CDB_ROB_tag),
        .cdb_value (CDB_value),
        .value     (OpAValue_DS),
        .tag       (OpA_RNB_index_DS),
        .rdy       (OpA_rdy_DS)
    );

    operand_capture #(
        .TAG_W (ROB_W)
    ) u_opb (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .hold      (full),
        .value_in  (OpBValue_DP),
        .tag_in    (OpB_RNB_index_DP),
        .rdy_in    (OpB_rdy_DP),
        .cdb_valid (CDB_valid),
        .cdb_tag   (CDB_ROB_tag),
        .cdb_value (CDB_value),
        .value     (OpBValue_DS),
        .tag       (OpB_RNB_index_DS),
        .rdy       (OpB_rdy_DS)
    );

endmodule

// File: tb/tb_dispatch_unit.sv
// Scoreboard bench for dispatch_unit: stimulus pushes expected dispatches,
// a negedge monitor pops and compares each time the DUT fires.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

module tb_dispatch_unit;
    import dispatch_unit_pkg::*;

    localparam int unsigned RW = `ROB_ENTRY_WIDTH;
    localparam int unsigned UW = DISP_UOP_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [UW-1:0] uop_DP;
    logic [31:0]   OpAValue_DP, OpBValue_DP, CDB_value;
    logic [RW-1:0] OpA_RNB_index_DP, OpB_RNB_index_DP, CDB_ROB_tag;
    logic          OpA_rdy_DP, OpB_rdy_DP, CDB_valid;
    logic [3:0]    RS_ready;
    logic          stall_DP;
    logic [UW-1:0] uop_DS;
    logic [31:0]   OpAValue_DS, OpBValue_DS;
    logic [RW-1:0] OpA_RNB_index_DS, OpB_RNB_index_DS;
    logic          OpA_rdy_DS, OpB_rdy_DS;
    logic [3:0]    disp_valid_DS;
    logic          illegal_fu_DS;

    typedef struct packed {
        logic [3:0]  dv;
        logic        ill;
        logic [31:0] inst;
        logic [31:0] a;
        logic        a_rdy;
        logic [31:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dispatch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .uop_DP           (uop_DP),
        .OpAValue_DP      (OpAValue_DP),
        .OpA_RNB_index_DP (OpA_RNB_index_DP),
        .OpA_rdy_DP       (OpA_rdy_DP),
        .OpBValue_DP      (OpBValue_DP),
        .OpB_RNB_index_DP (OpB_RNB_index_DP),
        .OpB_rdy_DP       (OpB_rdy_DP),
        .CDB_valid        (CDB_valid),
        .CDB_ROB_tag      (CDB_ROB_tag),
        .CDB_value        (CDB_value),
        .RS_ready         (RS_ready),
        .stall_DP         (stall_DP),
        .uop_DS           (uop_DS),
        .OpAValue_DS      (OpAValue_DS),
        .OpA_RNB_index_DS (OpA_RNB_index_DS),
        .OpA_rdy_DS       (OpA_rdy_DS),
        .OpBValue_DS      (OpBValue_DS),
        .OpB_RNB_index_DS (OpB_RNB_index_DS),
        .OpB_rdy_DS       (OpB_rdy_DS),
        .disp_valid_DS    (disp_valid_DS),
        .illegal_fu_DS    (illegal_fu_DS)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [UW-1:0] mk_uop(input logic [31:0] pc, input logic [31:0] inst,
                                             input logic [2:0] fu);
        logic [UW-1:0] u;
        u = '0;
        u[PC_LSB +: 32]            = pc;
        u[INST_LSB +: 32]          = inst;
        u[FUTYPE_LSB +: FUTYPE_W]  = fu;
        return u;
    endfunction

    task automatic drive(input logic [UW-1:0] u, input logic [31:0] a, input logic [RW-1:0] at,
                         input logic ar, input logic [31:0] b, input logic [RW-1:0] bt,
                         input logic br);
        uop_DP           = u;
        OpAValue_DP      = a;
        OpA_RNB_index_DP = at;
        OpA_rdy_DP       = ar;
        OpBValue_DP      = b;
        OpB_RNB_index_DP = bt;
        OpB_rdy_DP       = br;
    endtask

    task automatic bubble();
        drive('0, 32'h0, '0, 1'b0, 32'h0, '0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every fired dispatch (or dropped illegal) to the scoreboard
    always @(negedge clk) begin
        if (((disp_valid_DS & RS_ready) != 4'b0000) || illegal_fu_DS) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_dispatch", {disp_valid_DS, uop_DS[INST_LSB +: 32]}, '0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_disp_valid", disp_valid_DS, e.dv);
                chk("mon_illegal", illegal_fu_DS, e.ill);
                chk("mon_inst", uop_DS[INST_LSB +: 32], e.inst);
                chk("mon_opa_value", OpAValue_DS, e.a);
                chk("mon_opa_rdy", OpA_rdy_DS, e.a_rdy);
                chk("mon_opb_value", OpBValue_DS, e.b);
            end
        end
    end

    logic [UW-1:0] u_mem;
    logic [31:0]   snoop_a;
    logic          snoop_rdy;

    initial begin
        rst = 1'b1; flush = 1'b0; RS_ready = 4'b1111;
        CDB_valid = 1'b0; CDB_ROB_tag = '0; CDB_value = 32'h0;
        bubble();
        tick();
        tick();
        chk("rst_stall", stall_DP, 1'b0);
        chk("rst_disp_valid", disp_valid_DS, 4'b0000);
        chk("rst_illegal", illegal_fu_DS, 1'b0);
        chk("rst_uop", uop_DS, '0);
        chk("rst_opa", OpAValue_DS, 32'h0);
        rst = 1'b0;

        // ALU uop dispatches the cycle after capture
        drive(mk_uop(32'h100, 32'h00500093, FU_ALU), 32'h11, 6'd1, 1'b1, 32'h22, 6'd2, 1'b1);
        exp_q.push_back('{4'b0001, 1'b0, 32'h00500093, 32'h11, 1'b1, 32'h22});
        tick();
        chk("alu_disp_valid", disp_valid_DS, 4'b0001);
        chk("alu_stall", stall_DP, 1'b0);
        bubble();
        tick();
        chk("alu_empty_after", disp_valid_DS, 4'b0000);

        // MEM uop stalled 3 cycles by RS_ready[1]
        u_mem = mk_uop(32'h104, 32'h00002003, FU_MEM);
        RS_ready = 4'b1101;
        drive(u_mem, 32'h33, 6'd3, 1'b1, 32'h44, 6'd4, 1'b1);
        exp_q.push_back('{4'b0010, 1'b0, 32'h00002003, 32'h33, 1'b1, 32'h44});
        tick();
        bubble();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mem_stall", stall_DP, 1'b1);
            chk("mem_hold_uop", uop_DS, u_mem);
            chk("mem_hold_disp", disp_valid_DS, 4'b0010);
            tick();
        end
        RS_ready = 4'b1111;
        #1;
        chk("mem_release_stall", stall_DP, 1'b0);
        tick();
        chk("mem_empty_after", disp_valid_DS, 4'b0000);

        // Illegal FUType is dropped, next uop follows without stall
        drive(mk_uop(32'h108, 32'h00001234, 3'd7), 32'h55, 6'd5, 1'b1, 32'h66, 6'd6, 1'b1);
        exp_q.push_back('{4'b0000, 1'b1, 32'h00001234, 32'h55, 1'b1, 32'h66});
        tick();
        drive(mk_uop(32'h10c, 32'h00A00113, FU_ALU), 32'h77, 6'd7, 1'b1, 32'h88, 6'd8, 1'b1);
        exp_q.push_back('{4'b0001, 1'b0, 32'h00A00113, 32'h77, 1'b1, 32'h88});
        #1;
        chk("ill_pulse", illegal_fu_DS, 1'b1);
        chk("ill_disp_valid", disp_valid_DS, 4'b0000);
        chk("ill_stall", stall_DP, 1'b0);
        tick();
        chk("ill_pulse_end", illegal_fu_DS, 1'b0);
        chk("ill_next_disp", disp_valid_DS, 4'b0001);
        bubble();
        tick();

        // CDB wakeup of operand A while held
        RS_ready = 4'b0000;
        drive(mk_uop(32'h110, 32'h00C00213, FU_ALU), 32'h0, 6'd5, 1'b0, 32'h77, 6'd6, 1'b0);
        tick();
        bubble();
        CDB_valid = 1'b1; CDB_ROB_tag = 6'd5; CDB_value = 32'hDEADBEEF;
        tick();
        CDB_valid = 1'b0;
`ifdef DISPATCH_CDB_SNOOP_EN
        snoop_a = 32'hDEADBEEF; snoop_rdy = 1'b1;
`else
        snoop_a = 32'h0; snoop_rdy = 1'b0;
`endif
        chk("snoop_opa_value", OpAValue_DS, snoop_a);
        chk("snoop_opa_rdy", OpA_rdy_DS, snoop_rdy);
        chk("snoop_opb_value", OpBValue_DS, 32'h77);
        chk("snoop_opb_rdy", OpB_rdy_DS, 1'b0);
        RS_ready = 4'b1111;
        exp_q.push_back('{4'b0001, 1'b0, 32'h00C00213, snoop_a, snoop_rdy, 32'h77});
        tick();

        // Flush while full and stalled squashes the held and incoming uops
        RS_ready = 4'b0000;
        drive(mk_uop(32'h114, 32'h00003003, FU_MEM), 32'h1, 6'd1, 1'b1, 32'h2, 6'd2, 1'b1);
        tick();
        bubble();
        #1;
        chk("flush_pre_stall", stall_DP, 1'b1);
        flush = 1'b1;
        drive(mk_uop(32'h118, 32'h00B00193, FU_ALU), 32'h3, 6'd3, 1'b1, 32'h4, 6'd4, 1'b1);
        #1;
        chk("flush_stall", stall_DP, 1'b0);
        tick();
        flush = 1'b0;
        bubble();
        chk("flush_empty_stall", stall_DP, 1'b0);
        RS_ready = 4'b1111;
        #1;
        chk("flush_no_dispatch", disp_valid_DS, 4'b0000);
        tick();

        // Reset while full and stalled
        RS_ready = 4'b0000;
        drive(mk_uop(32'h11c, 32'h00004003, FU_MEM), 32'hAA, 6'd9, 1'b1, 32'hBB, 6'd10, 1'b1);
        tick();
        bubble();
        #1;
        chk("rst2_pre_stall", stall_DP, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst2_stall", stall_DP, 1'b0);
        chk("rst2_disp_valid", disp_valid_DS, 4'b0000);
        tick();
        rst = 1'b0;
        chk("rst2_uop", uop_DS, '0);
        chk("rst2_opa", OpAValue_DS, 32'h0);
        chk("rst2_opa_rdy", OpA_rdy_DS, 1'b0);
        chk("rst2_opb", OpBValue_DS, 32'h0);
        RS_ready = 4'b1111;
        #1;
        chk("rst2_empty_disp", disp_valid_DS, 4'b0000);
        chk("rst2_empty_stall", stall_DP, 1'b0);
        tick();
        tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
